// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe -- pipelined IEEE-754 style floating-point multiplier.
//
// Purpose: multiplies two {sign, exp, man} operands with per-transaction
// rounding mode; subnormals are read as signed zero and tiny results are
// flushed to signed zero. STAGES register levels with a global stall:
// the whole pipe advances when the output slot is empty or being consumed.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  operand handshake (in_ready = pipe advance)
//   fp_X, fp_Y         operands, W = 1+EXP_W+MAN_W bits
//   r_mode             000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, else RNE
//   out_valid/out_ready result handshake
//   fp_Z               product
//   ovrf, udrf, inv    overflow, underflow (flush), invalid-operation flags
module fp_mul_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   fp_X,
  input  logic [EXP_W+MAN_W:0]   fp_Y,
  input  logic [2:0]             r_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   fp_Z,
  output logic                   ovrf,
  output logic                   udrf,
  output logic                   inv
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * (MAN_W + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_TOP  = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EXP_W+1:0] BIAS    = (EXP_W+2)'((1 << (EXP_W-1)) - 1);
  localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] EXP_MIN = (EXP_W+2)'(1);

  // Global stall: everything moves together or nothing moves.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------- stage 1: classify, multiply significands ----------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  assign {sa, ea, ma} = fp_X;
  assign {sb, eb, mb} = fp_Y;

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  // exp == 0 covers both true zero and subnormals (read as zero).
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (ma == '0);
  assign b_inf  = (eb == EXP_ONES) && (mb == '0);
  assign a_nan  = (ea == EXP_ONES) && (ma != '0);
  assign b_nan  = (eb == EXP_ONES) && (mb != '0);
  assign a_snan = a_nan && !ma[MAN_W-1];
  assign b_snan = b_nan && !mb[MAN_W-1];

  logic                    sgn_d, spec_d, inv_d;
  logic [W-1:0]            spec_z_d;
  logic [PW-1:0]           prod_d;
  logic signed [EXP_W+1:0] exp_d;

  always_comb begin
    sgn_d    = sa ^ sb;
    spec_d   = 1'b1;
    inv_d    = 1'b0;
    spec_z_d = {W{1'b0}};
    if (a_nan || b_nan) begin
      spec_z_d = QNAN;
      inv_d    = a_snan || b_snan;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_z_d = QNAN;
      inv_d    = 1'b1;
    end else if (a_inf || b_inf) begin
      spec_z_d = {sgn_d, EXP_ONES, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      spec_z_d = {sgn_d, {(W-1){1'b0}}};
    end else begin
      spec_d = 1'b0;
    end
  end

  assign prod_d = PW'({1'b1, ma}) * PW'({1'b1, mb});
  assign exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

  logic                    s1_v_q, s1_sgn_q, s1_spec_q, s1_inv_q;
  logic [W-1:0]            s1_z_q;
  logic [PW-1:0]           s1_prod_q;
  logic signed [EXP_W+1:0] s1_exp_q;
  logic [2:0]              s1_mode_q;

  // ---------------- stage 2: normalise, round, range check ----------------
  logic                    hi, g, rb, st, inexact, inc, carry, to_max;
  logic [MAN_W-1:0]        frac;
  logic [MAN_W:0]          frac_r;
  logic signed [EXP_W+1:0] exp_n, exp_r;
  logic [W-1:0]            z_d;
  logic [2:0]              f_d;      // {ovrf, udrf, inv}

  always_comb begin
    // Product of two [1,2) significands lies in [1,4): one-bit normalise.
    hi      = s1_prod_q[PW-1];
    frac    = hi ? s1_prod_q[PW-2 -: MAN_W] : s1_prod_q[PW-3 -: MAN_W];
    g       = hi ? s1_prod_q[PW-2-MAN_W] : s1_prod_q[PW-3-MAN_W];
    rb      = hi ? s1_prod_q[PW-3-MAN_W] : s1_prod_q[PW-4-MAN_W];
    st      = hi ? |s1_prod_q[PW-4-MAN_W:0] : |s1_prod_q[PW-5-MAN_W:0];
    inexact = g | rb | st;
    case (s1_mode_q)
      3'b001:  inc = 1'b0;
      3'b010:  inc = s1_sgn_q & inexact;
      3'b011:  inc = ~s1_sgn_q & inexact;
      3'b100:  inc = g;
      default: inc = g & (rb | st | frac[0]);
    endcase
    // The hidden one is implicit: a carry out of the fraction means the
    // significand rounded up to 2.0, i.e. fraction 0 and exponent + 1.
    frac_r = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
    carry  = frac_r[MAN_W];
    exp_n  = s1_exp_q + $signed({{(EXP_W+1){1'b0}}, hi});
    exp_r  = exp_n + $signed({{(EXP_W+1){1'b0}}, carry});
    to_max = (s1_mode_q == 3'b001) ||
             (s1_mode_q == 3'b010 && !s1_sgn_q) ||
             (s1_mode_q == 3'b011 && s1_sgn_q);

    z_d = {s1_sgn_q, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
    f_d = 3'b000;
    if (s1_spec_q) begin
      z_d = s1_z_q;
      f_d = {2'b00, s1_inv_q};
    end else if (exp_r >= EXP_MAX) begin
      f_d = 3'b100;
      z_d = to_max ? {s1_sgn_q, EXP_TOP, {MAN_W{1'b1}}}
                   : {s1_sgn_q, EXP_ONES, {MAN_W{1'b0}}};
    end else if (exp_r < EXP_MIN) begin
      f_d = 3'b010;
      z_d = {s1_sgn_q, {(W-1){1'b0}}};
    end
  end

  // ---------------- result delay line (STAGES-1 levels) ----------------
  logic         res_v_q [STAGES-1];
  logic [W-1:0] res_z_q [STAGES-1];
  logic [2:0]   res_f_q [STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_sgn_q  <= 1'b0;
      s1_spec_q <= 1'b0;
      s1_inv_q  <= 1'b0;
      s1_z_q    <= '0;
      s1_prod_q <= '0;
      s1_exp_q  <= '0;
      s1_mode_q <= '0;
      for (int i = 0; i < STAGES-1; i++) begin
        res_v_q[i] <= 1'b0;
        res_z_q[i] <= '0;
        res_f_q[i] <= '0;
      end
    end else if (advance) begin
      s1_v_q    <= in_valid;
      s1_sgn_q  <= sgn_d;
      s1_spec_q <= spec_d;
      s1_inv_q  <= inv_d;
      s1_z_q    <= spec_z_d;
      s1_prod_q <= prod_d;
      s1_exp_q  <= exp_d;
      s1_mode_q <= r_mode;
      res_v_q[0] <= s1_v_q;
      res_z_q[0] <= z_d;
      res_f_q[0] <= f_d;
      for (int i = 1; i < STAGES-1; i++) begin
        res_v_q[i] <= res_v_q[i-1];
        res_z_q[i] <= res_z_q[i-1];
        res_f_q[i] <= res_f_q[i-1];
      end
    end
  end

  assign out_valid          = res_v_q[STAGES-2];
  assign fp_Z               = res_z_q[STAGES-2];
  assign {ovrf, udrf, inv}  = res_f_q[STAGES-2];

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa field width; W = 1+EXP_W+MAN_W.
REQ-003 SHALL have parameter STAGES, default 3, range 2..6, pipeline depth (latency in cycles without stall).
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  operand transaction offered.
REQ-007 in_ready  output  1  transaction accepted when in_valid && in_ready at clk edge.
REQ-008 fp_X  input  W  operand A, IEEE-754 layout {sign, exp, man}.
REQ-009 fp_Y  input  W  operand B.
REQ-010 r_mode  input  3  rounding mode, captured per transaction.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result when out_valid && out_ready.
REQ-013 fp_Z  output  W  product.
REQ-014 ovrf  output  1  overflow flag for fp_Z.
REQ-015 udrf  output  1  underflow (flush) flag for fp_Z.
REQ-016 inv  output  1  invalid-operation flag for fp_Z.

Function
REQ-017 r_mode: 000 RNE, 001 RTZ, 010 RDN (to -inf), 011 RUP (to +inf), 100 RMM (nearest, ties away); 101-111 SHALL behave as RNE.
REQ-018 Pipeline SHALL advance when !out_valid || out_ready; in_ready SHALL equal the advance condition (global stall, no bubble collapse).
REQ-019 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when out_ready held high; throughput one result per cycle.
REQ-020 Results SHALL leave in acceptance order; none dropped or duplicated under any out_ready pattern.
REQ-021 While stalled, fp_Z/ovrf/udrf/inv SHALL hold stable with out_valid high.
REQ-022 Sign = sign(X) xor sign(Y) for all non-NaN results.
REQ-023 Subnormal inputs (exp=0, man!=0) SHALL be treated as signed zero; no flag for this alone.
REQ-024 Normal*normal: full (MAN_W+1)x(MAN_W+1) product, exponent ea+eb-bias in EXP_W+2-bit signed arithmetic, 1-bit normalisation, guard+round+sticky rounding per r_mode; rounding carry SHALL renormalise (exp+1).
REQ-025 Overflow (rounded exp >= all-ones): ovrf=1; RNE/RMM -> signed inf; RTZ -> signed max finite; RDN -> +max finite if positive, -inf if negative; RUP -> +inf if positive, -max finite if negative.
REQ-026 Underflow (rounded exp < 1, nonzero product): fp_Z = signed zero, udrf=1.
REQ-027 Any NaN operand, or inf*zero: fp_Z = canonical qNaN (sign 0, exp all-ones, man MSB 1, rest 0); inv=1 only for sNaN input or inf*zero.
REQ-028 inf*nonzero finite or inf*inf: signed inf, all flags 0; zero*finite: signed zero, flags 0.
REQ-029 Exact results SHALL be independent of r_mode; result and flags SHALL be identical under operand swap (commutative) for every r_mode.
REQ-030 At most one of ovrf/udrf SHALL be set per result.

Reset
REQ-031 On rst high at clk edge: all stage valids cleared; out_valid=0, fp_Z=0, ovrf=0, udrf=0, inv=0 on next cycle.
REQ-032 in_ready SHALL be 1 in the cycle after reset release; in-flight transactions at reset SHALL be discarded, never emitted.
REQ-033 in_valid during rst SHALL not be accepted.

Verification (default params, STAGES=3)
REQ-034 3F800000*40000000, RNE, out_ready=1 -> 40000000 exactly 3 cycles after acceptance, flags 000.
REQ-035 7F000000*40000000: RNE -> 7F800000 ovrf=1; RTZ -> 7F7FFFFF ovrf=1; FF000000*40000000 RUP -> FF7FFFFF ovrf=1.
REQ-036 00800000*3F000000 any mode -> 00000000 udrf=1; 80800000*3F000000 -> 80000000 udrf=1.
REQ-037 7F800000*00000000 -> 7FC00000 inv=1; 7FC00001*3F800000 -> 7FC00000 inv=0; 7F800001*3F800000 -> 7FC00000 inv=1.
REQ-038 Issue 4 back-to-back, out_ready=0 for 6 cycles then 1 -> in_ready low while full, 4 results in order, none lost; rst asserted with 2 in flight -> no out_valid afterwards.
REQ-039 Random operands/r_mode into two instances with swapped fp_X/fp_Y, identical handshakes -> fp_Z, ovrf, udrf, inv bit-equal every cycle.
